dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder end of the data-memory interface; the memory stage is the initiator.
- Owns a 128 x 32-bit data store and accepts one load/store request per handshake.
- Performs byte/halfword/word lane selection, load sign/zero extension and misalignment detection.
- Returns a registered response over a valid/ready channel.

Parameters:
- ADDR_W, 7, word-address width (store depth = 2**ADDR_W words).
- DATA_W, 32, word width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_off  input  2  byte offset within word (lane 0 = bits 7:0, little-endian).
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  32  store data, right-aligned (byte in 7:0, half in 15:0).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts response.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal-size request.

Behaviour:
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready is 1 out of reset (combinational). Store contents are not reset.
- Handshake: request accepted on a rising edge with req_valid && req_ready. Response channel: transfer on rsp_valid && rsp_ready.
- req_ready = !rsp_valid || rsp_ready. One outstanding response; back-to-back accepts possible when the response drains in the same cycle.
- Latency: accept at edge N; rsp_valid=1 with rsp_rdata and rsp_err after edge N, and stable until the transferring edge.
- State machine has two states:
  - IDLE (rsp_valid=0): on accept, go to RESP.
  - RESP (rsp_valid=1): if rsp_ready and a new accept occur together, stay in RESP and load the new response.
  - RESP: if rsp_ready and no accept, go to IDLE.
  - RESP: if not rsp_ready, hold all response outputs.
- Response fields must not change while rsp_valid=1 && rsp_ready=0.
- Alignment: error if size=01 && off[0]=1, size=10 && off!=0, or size=11.
  - On error: no store update, rsp_err=1, rsp_rdata=0.
  - The request is still accepted and responded to.
- Loads (no error): read word mem[req_addr] at accept.
  - Byte: lane = off. Half: lane pair off[1].
  - Extend to 32 bits per req_unsigned. Word: whole word, req_unsigned ignored.
- Stores (no error): byte-enable write at the accepting edge.
  - Byte: enable lane off with wdata[7:0].
  - Half: enable lanes off, off+1 with wdata[15:0].
  - Word: all 4 lanes.
  - Unselected lanes keep their old value. Response: rsp_rdata=0, rsp_err=0.
- Read-after-write: a load accepted on the edge following a store to the same address returns the updated data.
- A load accepted in the same cycle as nothing else sees the store contents before that edge.
- Address is a full ADDR_W index; no wrap-around or out-of-range condition exists.
- Reset mid-operation: a pending response is dropped (rsp_valid=0 immediately, asynchronously). A store accepted on an edge coincident with reset assertion is not guaranteed. Contents written earlier are preserved.

Decomposition:
- Package dmem_pkg holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - ADDR_W default and the state encoding (ST_IDLE, ST_RESP).
- One combinational sub-module, dmem_lane_align, computes:
  - Misalignment error.
  - 4-bit byte enable and lane-replicated write data from size/off/wdata.
  - Extracted, extended load data from the read word.
- The top holds the store array, handshake FSM and response registers.

Test Plan:
- Reset, then store word 0xDEADBEEF @ addr 5, then load word @5 -> rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after accept.
- Store byte 0x80 @ addr 5 off 2, then load byte signed off 2 -> 0xFFFFFF80. Load byte unsigned -> 0x00000080. Load word -> 0xDE80BEEF.
- Load half off 1, and store word off 2 -> rsp_err=1, rsp_rdata=0, and a word load @5 confirms the contents are unchanged.
- Hold rsp_ready=0 for 3 cycles after a load -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0. Raise rsp_ready together with req_valid -> new request accepted the same edge, next response follows with no bubble.
- Stream 4 back-to-back word stores then loads to addrs 0 and 127 with rsp_ready=1 -> one accept per cycle, data correct at both address extremes.
- Assert reset while rsp_valid=1 -> rsp_valid=0 without a clock edge. After release, a load of a previously stored address returns the stored data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: widths, size codes, FSM states.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_LANES  = 4;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Response channel state: IDLE has no pending response, RESP holds one
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage (master) and the data store (slave).
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = dmem_pkg::ADDR_W_DEF
) ();

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [ADDR_W-1:0]           req_addr;
  logic [1:0]                  req_off;
  logic [1:0]                  req_size;
  logic                        req_unsigned;
  logic [dmem_pkg::DATA_W-1:0] req_wdata;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [dmem_pkg::DATA_W-1:0] rsp_rdata;
  logic                        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_off, req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_off, req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: alignment check, store byte enables/replication, load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        off_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic              err_o,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the read word
  always_comb begin
    byte_sel = rword_i[7:0];
    case (off_i)
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      2'd3:    byte_sel = rword_i[31:24];
      default: byte_sel = rword_i[7:0];
    endcase
    half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Decode size/offset into error, enables, replicated store data and extended load data
  always_comb begin
    err_o   = 1'b0;
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = '0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'(4'b0001 << off_i);
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        if (off_i[0]) begin
          err_o = 1'b1;
        end else begin
          be_o    = off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
          rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        end
      end
      SZ_WORD: begin
        if (off_i != 2'd0) begin
          err_o = 1'b1;
        end else begin
          be_o    = 4'b1111;
          rdata_o = rword_i;
        end
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: 2**ADDR_W x 32 store, one-deep registered response channel.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_e            state_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept_c;
  logic              wr_en_c;
  logic              err_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_rep_c;
  logic [DATA_W-1:0] rword_c;
  logic [DATA_W-1:0] ext_c;

  // Handshake: accept whenever the response slot is empty or draining this cycle
  assign bus.req_ready = (state_q == ST_IDLE) || bus.rsp_ready;
  assign accept_c      = bus.req_valid && bus.req_ready;
  assign wr_en_c       = accept_c && bus.req_write && !err_c && !reset;
  assign rword_c       = mem_q[bus.req_addr];

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  dmem_lane_align u_align (
    .size_i     (bus.req_size),
    .off_i      (bus.req_off),
    .unsigned_i (bus.req_unsigned),
    .wdata_i    (bus.req_wdata),
    .rword_i    (rword_c),
    .err_o      (err_c),
    .be_o       (be_c),
    .wdata_o    (wdata_rep_c),
    .rdata_o    (ext_c)
  );

  // Next response payload: loaded on accept, otherwise held
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept_c) begin
      err_d   = err_c;
      rdata_d = (err_c || bus.req_write) ? '0 : ext_c;
    end
  end

  // Response FSM and payload registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
      case (state_q)
        ST_IDLE: if (accept_c) state_q <= ST_RESP;
        ST_RESP: if (bus.rsp_ready && !accept_c) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Byte-enabled store write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (be_c[b]) mem_q[bus.req_addr][8*b +: 8] <= wdata_rep_c[8*b +: 8];
      end
    end
  end

endmodule
